sram_controller: RTL and testbench

- Responder for the MEM stage's data-memory request interface.
- Converts one 32-bit word read or write into two sequential 16-bit accesses on external asynchronous SRAM (16-bit DQ, 18-bit address).
- Deasserts `ready` while busy; the top level uses `~ready` as the pipeline freeze.
- Sits between MEM_Stage and the SRAM pins.

---
 rtl/sram_controller_pkg.sv | 25 ++
 rtl/sram_controller.sv | 136 +++++++++++++
 tb/tb_sram_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-to-16-bit SRAM controller.
package sram_controller_pkg;

  // Access sequencer states; exported on the debug port as-is.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } sram_state_e;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;
  // One 32-bit word occupies two halfwords, so the word index is one bit narrower.
  localparam int SRAM_IDX_W  = SRAM_ADDR_W - 1;

  localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;

  // Byte address -> SRAM word index. Out-of-range addresses wrap silently.
  function automatic logic [SRAM_IDX_W-1:0] word_index(input logic [31:0] addr,
                                                       input logic [31:0] base);
    return SRAM_IDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Data-memory responder: one 32-bit load/store becomes two 16-bit accesses
// on an asynchronous SRAM. ready low freezes the pipeline.
//
// Handshake: rd_en/wr_en are held by the requester until ready=1. A request
// is accepted when seen in IDLE; ready rises combinationally in DONE, and the
// requester advances (and drops or changes its request) on that DONE edge.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output sram_state_e            debug_state
);

  localparam int CNT_W = (HALF_CYCLES > 2) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

  sram_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q;
  logic [SRAM_IDX_W-1:0]  idx_q;
  logic [31:0]            wdata_q;
  logic [31:0]            read_data_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;

  logic                   req;
  logic                   half_last;
  logic                   dq_drive;
  logic [SRAM_DATA_W-1:0] dq_out;

  assign req       = rd_en | wr_en;
  assign half_last = (cnt_q == CNT_LAST);

  // State and per-half cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: each half lasts HALF_CYCLES cycles, DONE lasts one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACC_LO;
          cnt_d   = '0;
        end
      end
      ACC_LO: begin
        if (half_last) begin
          state_d = ACC_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACC_HI: begin
        if (half_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, halfword address and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        // Write wins when both enables are high.
        is_wr_q     <= wr_en;
        idx_q       <= word_index(address, BASE_ADDR);
        wdata_q     <= write_data;
        sram_addr_q <= {word_index(address, BASE_ADDR), 1'b0};
      end
      if (state_q == ACC_LO && half_last) begin
        sram_addr_q <= {idx_q, 1'b1};
        if (!is_wr_q) read_data_q[15:0] <= SRAM_DQ;
      end
      if (state_q == ACC_HI && half_last && !is_wr_q) begin
        read_data_q[31:16] <= SRAM_DQ;
      end
    end
  end

  // Write strobe is held high on the first cycle of each half for address setup.
  always_comb begin
    dq_drive  = is_wr_q && (state_q == ACC_LO || state_q == ACC_HI);
    dq_out    = (state_q == ACC_HI) ? wdata_q[31:16] : wdata_q[15:0];
    SRAM_WE_N = ~(dq_drive && (cnt_q != '0));
    ready     = (state_q == IDLE && !req) || (state_q == DONE);
  end

  assign SRAM_DQ     = dq_drive ? dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR   = sram_addr_q;
  assign read_data   = read_data_q;
  assign debug_state = state_q;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_OE_N   = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model, word-level reference map,
// directed scenarios followed by randomized traffic.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int unsigned BASE = 1024;
  localparam int unsigned HC   = 2;
  localparam int unsigned LAT  = 2 * HC + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;
  sram_state_e debug_state;

  sram_controller #(.BASE_ADDR(BASE), .HALF_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .debug_state(debug_state)
  );

  // ---------------- async SRAM model (256K x 16) ----------------
  logic [15:0] mem [0:262143];
  bit          model_oe;
  assign sram_dq = (model_oe && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(negedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_word [int unsigned];
  logic [31:0] exp_q [$];
  logic [31:0] last_read = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_idx(input logic [31:0] addr);
    return ((addr - BASE) >> 2) & 32'h1FFFF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      check_val("idle_ready", {31'd0, ready}, 32'd1);
      check_val("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned idx, half, pos;
    bit          is_w;
    logic [31:0] exp_rd;
    @(negedge clk);
    check_val("gap_idle", {30'd0, debug_state}, {30'd0, IDLE});
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    is_w = wr;
    model_oe = !is_w;
    idx = ref_idx(addr);
    if (!is_w) exp_q.push_back(ref_word.exists(idx) ? ref_word[idx] : 32'd0);
    #1;
    check_val("ready_c0", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) begin
        address = $urandom; write_data = $urandom;
      end
      #1;
      check_val("ready_lat", {31'd0, ready}, (c == LAT) ? 32'd1 : 32'd0);
      if (c < LAT) begin
        half = (c - 1) / HC;
        pos  = (c - 1) % HC;
        check_val("we_n", {31'd0, sram_we_n}, (is_w && pos != 0) ? 32'd0 : 32'd1);
        check_val("sram_addr", {14'd0, sram_addr}, (idx << 1) | half);
        check_val("dq_drive", {31'd0, dut.dq_drive}, {31'd0, is_w});
        if (is_w) check_val("dq_data", {16'd0, sram_dq}, half ? {16'd0, wd[31:16]} : {16'd0, wd[15:0]});
      end else if (is_w) begin
        ref_word[idx] = wd;
        check_val("mem_lo", {16'd0, mem[2*idx]}, {16'd0, wd[15:0]});
        check_val("mem_hi", {16'd0, mem[2*idx+1]}, {16'd0, wd[31:16]});
        check_val("rd_hold", read_data, last_read);
      end else begin
        exp_rd = exp_q.pop_front();
        check_val("rd_data", read_data, exp_rd);
        last_read = exp_rd;
      end
    end
    model_oe = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
  end

  initial begin
    logic [31:0] a, d;
    int op;
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0;
    address = 32'd1028; write_data = 32'd0; model_oe = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_rdata", read_data, 32'd0);
    check_val("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_val("rst_dq_z", {31'd0, dut.dq_drive}, 32'd0);
    check_val("rst_state", {30'd0, debug_state}, {30'd0, IDLE});
    check_val("rst_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1;
    check_val("post_rst_state", {30'd0, debug_state}, {30'd0, IDLE});
    check_val("post_rst_ready", {31'd0, ready}, 32'd1);

    // Write then read, back to back.
    access(1, 0, 32'd1028, 32'hDEADBEEF);
    check_val("word2", {16'd0, mem[2]}, 32'h0000BEEF);
    check_val("word3", {16'd0, mem[3]}, 32'h0000DEAD);
    access(0, 1, 32'd1028, 32'd0);
    check_val("rd_1028", read_data, 32'hDEADBEEF);

    idle(10);

    access(1, 0, 32'd1024, 32'h12345678);
    access(0, 1, 32'd1024, 32'd0);
    access(1, 0, 32'd1032, 32'hCAFEF00D);
    check_val("rd_hold_1024", read_data, 32'h12345678);
    idle(1);

    // Both enables: write wins.
    access(1, 1, 32'd1040, 32'hA5A50F0F);
    check_val("word8", {16'd0, mem[8]}, 32'h00000F0F);
    check_val("word9", {16'd0, mem[9]}, 32'h0000A5A5);
    check_val("both_rd_hold", read_data, 32'h12345678);
    idle(2);

    // Reset during the third access cycle of a read.
    @(negedge clk);
    rd_en = 1'b1; address = 32'd1028; model_oe = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("mid_state", {30'd0, debug_state}, {30'd0, ACC_HI});
    rst = 1'b1; rd_en = 1'b0; model_oe = 1'b0;
    @(negedge clk); #1;
    check_val("abort_state", {30'd0, debug_state}, {30'd0, IDLE});
    check_val("abort_ready", {31'd0, ready}, 32'd1);
    check_val("abort_rdata", read_data, 32'd0);
    check_val("abort_dq_z", {31'd0, dut.dq_drive}, 32'd0);
    rst = 1'b0;
    last_read = 32'd0;
    idle(1);

    // Randomized traffic against the word-level reference map.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      d  = $urandom;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, a, d);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
